// File: rtl/register_file_pkg.sv
// Shared sizing helpers for the general register set.
//   addr_w(n)      : address width for n registers, never less than one bit
//   rf_addr_t      : wide address container used for range comparisons so that
//                    a narrow port address and a register count can be compared
//                    without width games at every call site
//   addr_usable()  : true when an address names a real, writable register
//                    (in range and not the hardwired zero register)
package register_file_pkg;

  localparam int RF_ADDR_MAX_W = 16;

  typedef logic [RF_ADDR_MAX_W-1:0] rf_addr_t;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic addr_usable(input rf_addr_t addr,
                                       input int       num_regs,
                                       input bit       zero_reg);
    return (addr < rf_addr_t'(num_regs)) && !(zero_reg && (addr == '0));
  endfunction

endpackage

// File: rtl/register_file_n_read_port.sv
// One registered read port of the register file.
// Decodes the read address against the parent's storage array, applies the
// range / zero-register rules, forwards a same-cycle write (bypass) and
// registers the result with one cycle of latency.
// Ports:
//   clock, reset, enable      : clock, synchronous active-high reset, global enable
//   rd_en, rd_addr            : read request and address
//   wr_en, wr_addr, wr_data   : the write port, observed for bypass
//   regs, pending             : storage array and scoreboard owned by the parent
//   rd_data, busy             : registered read data and "was pending" flag
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8,
  parameter bit ZERO_REG  = 1'b1,
  parameter int ADDR_W    = addr_w(NUM_REGS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               rd_en,
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [WORD_SIZE-1:0]               wr_data,
  input  logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs,
  input  logic [NUM_REGS-1:0]                pending,
  output logic [WORD_SIZE-1:0]               rd_data,
  output logic                               busy
);

  logic                 usable;
  logic                 hit_wr;
  logic [WORD_SIZE-1:0] word_sel;
  logic                 pend_sel;
  logic [WORD_SIZE-1:0] data_p0;
  logic                 busy_p0;

  // Stage 0: decode, range/zero qualification and bypass selection.
  // The select is a compare-per-register loop rather than a direct index so a
  // non-power-of-two register count never produces an out-of-bounds access.
  always_comb begin
    usable   = addr_usable(rf_addr_t'(rd_addr), NUM_REGS, ZERO_REG);
    hit_wr   = wr_en && (wr_addr == rd_addr);
    word_sel = '0;
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        word_sel = regs[i];
        pend_sel = pending[i];
      end
    end
    data_p0 = '0;
    busy_p0 = 1'b0;
    if (usable) begin
      data_p0 = hit_wr ? wr_data : word_sel;
      // A write landing this cycle clears the reservation, so the reader
      // receives the fresh value and must not see it as still pending.
      busy_p0 = pend_sel && !hit_wr;
    end
  end

  // Stage 1: output registers; hold whenever the port is idle or disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      busy    <= 1'b0;
    end else if (enable && rd_en) begin
      rd_data <= data_p0;
      busy    <= busy_p0;
    end
  end

endmodule

// File: rtl/register_file_n.sv
// General register set: NUM_REGS words of WORD_SIZE bits with two registered
// read ports (A, B), one write port, same-cycle write-to-read bypass and a
// per-register pending scoreboard for values awaiting writeback.
// Ports:
//   clock, reset, enable          : clock, synchronous active-high reset, global enable
//   rd_en_a, rd_addr_a            : port A read request / address
//   rd_data_a, busy_a             : port A registered data / pending flag
//   rd_en_b, rd_addr_b            : port B read request / address
//   rd_data_b, busy_b             : port B registered data / pending flag
//   wr_en, wr_addr, wr_data       : write request, address, data
//   rsv_en, rsv_addr              : reservation request, address
//   pending                       : live scoreboard, bit i = register i pending
module register_file_n
  import register_file_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 8,
  parameter  bit ZERO_REG  = 1'b1,
  localparam int ADDR_W    = addr_w(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rd_en_a,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [WORD_SIZE-1:0] rd_data_a,
  output logic                 busy_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WORD_SIZE-1:0] rd_data_b,
  output logic                 busy_b,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs;
  logic [NUM_REGS-1:0]                wr_hit;
  logic [NUM_REGS-1:0]                rsv_hit;

  // Stage 0: per-register write / reserve decode. Out-of-range addresses match
  // no register and the zero register is excluded, so both are dropped here.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG && (i == 0))) begin
        wr_hit[i]  = wr_en  && (wr_addr  == ADDR_W'(i));
        rsv_hit[i] = rsv_en && (rsv_addr == ADDR_W'(i));
      end
    end
  end

  // Stage 1: storage and scoreboard. A reservation wins over the clear from a
  // simultaneous write: the data lands but the register stays pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs    <= '0;
      pending <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_data;
        end
        if (rsv_hit[i]) begin
          pending[i] <= 1'b1;
        end else if (wr_hit[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  rf_read_port #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG  (ZERO_REG),
    .ADDR_W    (ADDR_W)
  ) u_port_a (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .rd_en   (rd_en_a),
    .rd_addr (rd_addr_a),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs),
    .pending (pending),
    .rd_data (rd_data_a),
    .busy    (busy_a)
  );

  rf_read_port #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG  (ZERO_REG),
    .ADDR_W    (ADDR_W)
  ) u_port_b (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .rd_en   (rd_en_b),
    .rd_addr (rd_addr_b),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs),
    .pending (pending),
    .rd_data (rd_data_b),
    .busy    (busy_b)
  );

endmodule

// File: tb/tb_register_file_n.sv
// Bench for register_file_n with 7 registers (non-power-of-two, so address 7
// is out of range) and a hardwired zero register.
module tb_register_file_n;

  localparam int N  = 7;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset, enable;
  logic          rd_en_a, rd_en_b, wr_en, rsv_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          busy_a, busy_b;
  logic [N-1:0]  pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_regs [N];
  logic         m_pend [N];
  logic [W-1:0] m_rd_a, m_rd_b;
  logic         m_busy_a, m_busy_b;

  register_file_n #(.WORD_SIZE(W), .NUM_REGS(N), .ZERO_REG(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .busy_a    (busy_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  function automatic bit real_reg(input logic [AW-1:0] a);
    return (int'(a) < N) && (a != 0);
  endfunction

  function automatic logic [N-1:0] exp_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic model_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic b);
    bit wr_same;
    wr_same = wr_en && (wr_addr == a);
    d = '0;
    b = 1'b0;
    if (real_reg(a)) begin
      d = wr_same ? wr_data : m_regs[int'(a)];
      b = m_pend[int'(a)] && !wr_same;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_rd_a = '0; m_rd_b = '0; m_busy_a = 1'b0; m_busy_b = 1'b0;
    end else if (enable) begin
      if (rd_en_a) model_read(rd_addr_a, m_rd_a, m_busy_a);
      if (rd_en_b) model_read(rd_addr_b, m_rd_b, m_busy_b);
      if (wr_en && real_reg(wr_addr)) begin
        m_regs[int'(wr_addr)] = wr_data;
        m_pend[int'(wr_addr)] = 1'b0;
      end
      if (rsv_en && real_reg(rsv_addr)) m_pend[int'(rsv_addr)] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; enable = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle(); wr_en = 1'b1; wr_addr = 3; wr_data = 8'h55; tick();
    idle(); rsv_en = 1'b1; rsv_addr = 2;
    rd_en_a = 1'b1; rd_addr_a = 3; rd_en_b = 1'b1; rd_addr_b = 3; tick();
    checks++; if (rd_data_a !== 8'h55) begin errors++; $display("FAIL pre_reset_rd_a got %h want 55", rd_data_a); end
    idle(); reset = 1'b1; rd_en_a = 1'b1; rd_addr_a = 3; wr_en = 1'b1; wr_addr = 1; wr_data = 8'hAA; tick();
    checks++; if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin errors++; $display("FAIL reset_rd got a=%h b=%h want 00", rd_data_a, rd_data_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got a=%b b=%b want 0", busy_a, busy_b); end
    checks++; if (pending !== 7'd0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    idle(); rd_en_a = 1'b1; rd_addr_a = 3; rd_en_b = 1'b1; rd_addr_b = 1; tick();
    checks++; if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin errors++; $display("FAIL reset_regs got r3=%h r1=%h want 00", rd_data_a, rd_data_b); end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1'b1; wr_addr = 5; wr_data = 8'hA7; tick();
    idle(); rd_en_a = 1'b1; rd_addr_a = 5; tick();
    checks++; if (rd_data_a !== 8'hA7) begin errors++; $display("FAIL write_read got %h want a7", rd_data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL write_read_busy got %b want 0", busy_a); end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1'b1; wr_addr = 2; wr_data = 8'h3C;
    rd_en_a = 1'b1; rd_addr_a = 2; rd_en_b = 1'b1; rd_addr_b = 2; tick();
    checks++; if (rd_data_a !== 8'h3C) begin errors++; $display("FAIL bypass_a got %h want 3c", rd_data_a); end
    checks++; if (rd_data_b !== 8'h3C) begin errors++; $display("FAIL bypass_b got %h want 3c", rd_data_b); end
  endtask

  task automatic test_scoreboard();
    idle(); rsv_en = 1'b1; rsv_addr = 4; tick();
    checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL rsv_pending got %b want 1", pending[4]); end
    idle(); rd_en_a = 1'b1; rd_addr_a = 4; tick();
    checks++; if (busy_a !== 1'b1 || rd_data_a !== 8'h00) begin errors++; $display("FAIL rsv_read got busy=%b d=%h want 1 00", busy_a, rd_data_a); end
    idle(); wr_en = 1'b1; wr_addr = 4; wr_data = 8'h11; tick();
    checks++; if (pending[4] !== 1'b0) begin errors++; $display("FAIL wb_clear got %b want 0", pending[4]); end
    idle(); wr_en = 1'b1; wr_addr = 6; wr_data = 8'h9D; rsv_en = 1'b1; rsv_addr = 6; tick();
    checks++; if (pending[6] !== 1'b1) begin errors++; $display("FAIL rsv_wr_pending got %b want 1", pending[6]); end
    idle(); rd_en_a = 1'b1; rd_addr_a = 6; rd_en_b = 1'b1; rd_addr_b = 4; tick();
    checks++; if (rd_data_a !== 8'h9D || busy_a !== 1'b1) begin errors++; $display("FAIL rsv_wr_data got d=%h busy=%b want 9d 1", rd_data_a, busy_a); end
    checks++; if (rd_data_b !== 8'h11 || busy_b !== 1'b0) begin errors++; $display("FAIL wb_read got d=%h busy=%b want 11 0", rd_data_b, busy_b); end
  endtask

  task automatic test_zero_range();
    idle(); wr_en = 1'b1; wr_addr = 0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 0; tick();
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL zero_pending got %b want 0", pending[0]); end
    idle(); rd_en_a = 1'b1; rd_addr_a = 0; rd_en_b = 1'b1; rd_addr_b = 7;
    wr_en = 1'b1; wr_addr = 0; wr_data = 8'hFF; tick();
    checks++; if (rd_data_a !== 8'h00 || busy_a !== 1'b0) begin errors++; $display("FAIL zero_read got d=%h busy=%b want 00 0", rd_data_a, busy_a); end
    checks++; if (rd_data_b !== 8'h00 || busy_b !== 1'b0) begin errors++; $display("FAIL range_read got d=%h busy=%b want 00 0", rd_data_b, busy_b); end
    idle(); wr_en = 1'b1; wr_addr = 7; wr_data = 8'h77; rsv_en = 1'b1; rsv_addr = 7;
    rd_en_a = 1'b1; rd_addr_a = 7; tick();
    checks++; if (rd_data_a !== 8'h00 || pending !== 7'b1000000) begin errors++; $display("FAIL range_write got d=%h pend=%b want 00 1000000", rd_data_a, pending); end
  endtask

  task automatic test_enable();
    idle(); rd_en_a = 1'b1; rd_addr_a = 5; rd_en_b = 1'b1; rd_addr_b = 6; tick();
    idle(); enable = 1'b0; wr_en = 1'b1; wr_addr = 5; wr_data = 8'hEE; rsv_en = 1'b1; rsv_addr = 1;
    rd_en_a = 1'b1; rd_addr_a = 2; rd_en_b = 1'b1; rd_addr_b = 0; tick();
    checks++; if (rd_data_a !== 8'hA7 || rd_data_b !== 8'h9D || busy_b !== 1'b1) begin errors++; $display("FAIL enable_hold got a=%h b=%h busy_b=%b want a7 9d 1", rd_data_a, rd_data_b, busy_b); end
    checks++; if (pending !== 7'b1000000) begin errors++; $display("FAIL enable_pending got %b want 1000000", pending); end
    idle(); rd_en_a = 1'b1; rd_addr_a = 5; rd_en_b = 1'b1; rd_addr_b = 2; tick();
    checks++; if (rd_data_a !== 8'hA7 || rd_data_b !== 8'h3C) begin errors++; $display("FAIL enable_resume got a=%h b=%h want a7 3c", rd_data_a, rd_data_b); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      rd_en_a   = $urandom_range(0, 3) != 0;
      rd_en_b   = $urandom_range(0, 3) != 0;
      wr_en     = $urandom_range(0, 1) == 1;
      rsv_en    = $urandom_range(0, 2) == 0;
      rd_addr_a = AW'($urandom_range(0, 7));
      rd_addr_b = AW'($urandom_range(0, 7));
      wr_addr   = AW'($urandom_range(0, 7));
      rsv_addr  = AW'($urandom_range(0, 7));
      wr_data   = W'($urandom);
      tick();
      checks++; if (rd_data_a !== m_rd_a || busy_a !== m_busy_a) begin errors++; $display("FAIL rand_a cyc %0d got %h/%b want %h/%b", n, rd_data_a, busy_a, m_rd_a, m_busy_a); end
      checks++; if (rd_data_b !== m_rd_b || busy_b !== m_busy_b) begin errors++; $display("FAIL rand_b cyc %0d got %h/%b want %h/%b", n, rd_data_b, busy_b, m_rd_b, m_busy_b); end
      checks++; if (pending !== exp_pending()) begin errors++; $display("FAIL rand_pending cyc %0d got %b want %b", n, pending, exp_pending()); end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_range();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
